// File: rtl/mem_port_arbiter_pkg.sv
// ============================================================================
//  Module      : mem_arb_pkg
//  Description : Shared types and helpers for the unified-memory port arbiter:
//                FSM state encoding, port owner codes, counter sizing function.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package mem_arb_pkg;

  // Transaction sequencer states
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    WAIT   = 2'b10,
    RESP   = 2'b11
  } state_t;

  // Owner codes for the two requesting ports
  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_LDR = 1'b1;

  // Number of bits needed to hold values 0 .. value-1
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_port_arbiter_if.sv
// ============================================================================
//  Module      : mem_port_arbiter_if
//  Description : Bundles the CPU port, loader port, memory-macro port and
//                status signals of the arbiter. The slave modport is the
//                arbiter's view; master is the surrounding system's view.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface mem_port_arbiter_if #(
  parameter int AW = 8,
  parameter int DW = 32
);
  // CPU port
  logic          c_req;
  logic          c_we;
  logic [AW-1:0] c_addr;
  logic [DW-1:0] c_wdata;
  logic [DW-1:0] c_rdata;
  logic          c_ack;
  // Loader / debug port
  logic          l_req;
  logic          l_we;
  logic [AW-1:0] l_addr;
  logic [DW-1:0] l_wdata;
  logic [DW-1:0] l_rdata;
  logic          l_ack;
  // Memory macro
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  // Status
  logic          busy;
  logic          owner;

  modport slave (
    input  c_req, c_we, c_addr, c_wdata,
    output c_rdata, c_ack,
    input  l_req, l_we, l_addr, l_wdata,
    output l_rdata, l_ack,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata,
    output busy, owner
  );

  modport master (
    output c_req, c_we, c_addr, c_wdata,
    input  c_rdata, c_ack,
    output l_req, l_we, l_addr, l_wdata,
    input  l_rdata, l_ack,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata,
    input  busy, owner
  );

endinterface

`default_nettype wire

// File: rtl/mem_port_arbiter_arb_pick.sv
// ============================================================================
//  Module      : arb_pick
//  Description : Combinational grant selection between CPU and loader ports.
//                Default: loader wins ties. With ARB_ROUND_ROBIN_EN defined,
//                a tie goes to the port that did not own the last transaction.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module arb_pick
  import mem_arb_pkg::*;
(
  input  logic c_req,
  input  logic l_req,
`ifdef ARB_ROUND_ROBIN_EN
  input  logic last_owner,
`endif
  output logic grant,
  output logic owner
);

  // Any request produces a grant; a lone requester always wins
  always_comb begin
    grant = c_req | l_req;
`ifdef ARB_ROUND_ROBIN_EN
    if (c_req && l_req) owner = ~last_owner;
    else                owner = l_req ? OWN_LDR : OWN_CPU;
`else
    owner = l_req ? OWN_LDR : OWN_CPU;
`endif
  end

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
//  Module      : mem_port_arbiter
//  Description : Shares one memory macro between the CPU port and the loader
//                port. One memory access per transaction, latency counted
//                out over MEM_LAT cycles, one-cycle ack to the owning port.
//                Optional macro ARB_ROUND_ROBIN_EN selects round-robin ties.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW      = 8,
  parameter int DW      = 32,
  parameter int MEM_LAT = 1
) (
  input  logic               clk,
  input  logic               reset,
  mem_port_arbiter_if.slave  bus
);

  localparam int CW = clog2(MEM_LAT + 1);

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_we;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic          r_owner;
  logic          r_busy;
  logic          r_mem_en;
  logic          r_mem_we;
  logic          r_c_ack;
  logic          r_l_ack;
  logic [DW-1:0] r_c_rdata;
  logic [DW-1:0] r_l_rdata;
  logic          w_grant;
  logic          w_owner;

`ifdef ARB_ROUND_ROBIN_EN
  logic          r_last_owner;

  arb_pick u_pick (
    .c_req      (bus.c_req),
    .l_req      (bus.l_req),
    .last_owner (r_last_owner),
    .grant      (w_grant),
    .owner      (w_owner)
  );

  // Remember the owner of each granted transaction; CPU wins the first tie
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                         r_last_owner <= OWN_LDR;
    else if (r_state == IDLE && w_grant) r_last_owner <= w_owner;
  end
`else
  arb_pick u_pick (
    .c_req (bus.c_req),
    .l_req (bus.l_req),
    .grant (w_grant),
    .owner (w_owner)
  );
`endif

  // Transaction sequencer with registered strobes, acks and read data
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_owner   <= OWN_CPU;
      r_busy    <= 1'b0;
      r_mem_en  <= 1'b0;
      r_mem_we  <= 1'b0;
      r_c_ack   <= 1'b0;
      r_l_ack   <= 1'b0;
      r_c_rdata <= '0;
      r_l_rdata <= '0;
    end else begin
      r_mem_en <= 1'b0;
      r_mem_we <= 1'b0;
      r_c_ack  <= 1'b0;
      r_l_ack  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_grant) begin
            // Latch the winner's request; port inputs are ignored from here on
            r_owner  <= w_owner;
            r_we     <= (w_owner == OWN_LDR) ? bus.l_we    : bus.c_we;
            r_addr   <= (w_owner == OWN_LDR) ? bus.l_addr  : bus.c_addr;
            r_wdata  <= (w_owner == OWN_LDR) ? bus.l_wdata : bus.c_wdata;
            r_mem_en <= 1'b1;
            r_mem_we <= (w_owner == OWN_LDR) ? bus.l_we    : bus.c_we;
            r_busy   <= 1'b1;
            r_state  <= ACCESS;
          end
        end
        ACCESS: begin
          r_cnt   <= CW'(MEM_LAT);
          r_state <= WAIT;
        end
        WAIT: begin
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            // Read data is valid only in the last wait cycle
            if (!r_we) begin
              if (r_owner == OWN_LDR) r_l_rdata <= bus.mem_rdata;
              else                    r_c_rdata <= bus.mem_rdata;
            end
            if (r_owner == OWN_LDR) r_l_ack <= 1'b1;
            else                    r_c_ack <= 1'b1;
            r_state <= RESP;
          end
        end
        RESP: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.mem_en    = r_mem_en;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_addr;
  assign bus.mem_wdata = r_wdata;
  assign bus.c_ack     = r_c_ack;
  assign bus.l_ack     = r_l_ack;
  assign bus.c_rdata   = r_c_rdata;
  assign bus.l_rdata   = r_l_rdata;
  assign bus.busy      = r_busy;
  assign bus.owner     = r_owner;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
//  Module      : tb_mem_port_arbiter
//  Description : Self-checking bench for mem_port_arbiter. A transaction-level
//                model predicts service order, ack cycles and read data.
//                A second instance runs with MEM_LAT=3.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int AW   = 8;
  localparam int DW   = 32;
  localparam int LAT  = 1;
  localparam int LAT3 = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus  ();
  mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus3 ();

  mem_port_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(LAT))  u_dut  (.clk(clk), .reset(reset), .bus(bus));
  mem_port_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(LAT3)) u_dut3 (.clk(clk), .reset(reset), .bus(bus3));

  // Memory macro models: read data valid MEM_LAT cycles after mem_en, junk otherwise
  logic [DW-1:0] mem  [256];
  logic [DW-1:0] mem3 [256];
  logic [DW-1:0] junk = '0;
  logic [DW-1:0] rd1  = '0;
  logic          rv1  = 1'b0;
  logic [2:0]    pv3  = 3'b000;
  logic [DW-1:0] pd3  [3];
  logic          ld_we  = 1'b0;
  logic          ld_sel = 1'b0;
  logic [AW-1:0] ld_a   = '0;
  logic [DW-1:0] ld_d   = '0;

  always @(posedge clk) begin
    junk <= $urandom;
    rv1  <= bus.mem_en && !bus.mem_we;
    rd1  <= mem[bus.mem_addr];
    if (bus.mem_en && bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
    else if (ld_we && !ld_sel)    mem[ld_a] <= ld_d;
    pv3    <= {pv3[1:0], bus3.mem_en && !bus3.mem_we};
    pd3[0] <= mem3[bus3.mem_addr];
    pd3[1] <= pd3[0];
    pd3[2] <= pd3[1];
    if (ld_we && ld_sel) mem3[ld_a] <= ld_d;
  end

  assign bus.mem_rdata  = rv1    ? rd1    : junk;
  assign bus3.mem_rdata = pv3[2] ? pd3[2] : junk;

  // Reference model state
  logic [DW-1:0] ref_mem [256];
  logic [DW-1:0] exp_c = '0;
  logic [DW-1:0] exp_l = '0;
  bit            model_last = 1'b1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic mem_load(input bit sel, input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    ld_sel = sel; ld_a = a; ld_d = d; ld_we = 1'b1;
    @(negedge clk);
    ld_we = 1'b0;
  endtask

  // One round: requests presented together in an IDLE cycle, each held until acked
  task automatic run_round(input bit rc, input bit rl, input bit cwe, input bit lwe,
                           input logic [AW-1:0] ca, input logic [AW-1:0] la,
                           input logic [DW-1:0] cd, input logic [DW-1:0] ld,
                           input bit drop, input bit scramble);
    bit            own [2];
    logic [AW-1:0] ta  [2];
    bit            twe [2];
    logic [DW-1:0] twd [2];
    int n, ci, li, c_acks, l_acks, en_n;
    n = 0; ci = -1; li = -1; c_acks = 0; l_acks = 0; en_n = 0;
    if (rc && rl) begin
`ifdef ARB_ROUND_ROBIN_EN
      own[0] = ~model_last;
`else
      own[0] = OWN_LDR;
`endif
      own[1] = ~own[0];
      n = 2;
    end else begin
      own[0] = rl;
      own[1] = ~rl;
      n = 1;
    end
    for (int i = 0; i < n; i++) begin
      ta[i]  = own[i] ? la  : ca;
      twe[i] = own[i] ? lwe : cwe;
      twd[i] = own[i] ? ld  : cd;
      if (own[i]) li = i; else ci = i;
      model_last = own[i];
      if (twe[i])      ref_mem[ta[i]] = twd[i];
      else if (own[i]) exp_l = ref_mem[ta[i]];
      else             exp_c = ref_mem[ta[i]];
    end

    @(negedge clk);
    bus.c_req = rc; bus.c_we = cwe; bus.c_addr = ca; bus.c_wdata = cd;
    bus.l_req = rl; bus.l_we = lwe; bus.l_addr = la; bus.l_wdata = ld;
    for (int k = 1; k <= 2*LAT + 8; k++) begin
      @(negedge clk);
      if (k == 1) begin
        check("busy", 32'(bus.busy), 32'd1);
        check("owner", 32'(bus.owner), 32'(own[0]));
      end
      if (bus.mem_en) begin
        if (en_n < n) begin
          check("mem_en_time", k, 1 + en_n*(LAT+3));
          check("mem_addr", 32'(bus.mem_addr), 32'(ta[en_n]));
          check("mem_we", 32'(bus.mem_we), 32'(twe[en_n]));
          if (twe[en_n]) check("mem_wdata", bus.mem_wdata, twd[en_n]);
        end
        en_n++;
      end
      if (drop && k == 1) begin
        if (own[0]) bus.l_req = 1'b0; else bus.c_req = 1'b0;
      end
      if (scramble && k == 2) begin
        if (own[0]) begin bus.l_addr = AW'($urandom); bus.l_wdata = $urandom; bus.l_we = ~bus.l_we; end
        else        begin bus.c_addr = AW'($urandom); bus.c_wdata = $urandom; bus.c_we = ~bus.c_we; end
      end
      if (scramble && k == LAT + 2) check("mem_addr_hold", 32'(bus.mem_addr), 32'(ta[0]));
      if (bus.c_ack) begin
        c_acks++;
        check("c_ack_time", k, LAT + 2 + ci*(LAT+3));
        check("c_rdata", bus.c_rdata, exp_c);
        bus.c_req = 1'b0;
      end
      if (bus.l_ack) begin
        l_acks++;
        check("l_ack_time", k, LAT + 2 + li*(LAT+3));
        check("l_rdata", bus.l_rdata, exp_l);
        bus.l_req = 1'b0;
      end
    end
    check("c_ack_count", c_acks, rc ? 1 : 0);
    check("l_ack_count", l_acks, rl ? 1 : 0);
    check("mem_en_count", en_n, n);
    check("c_rdata_end", bus.c_rdata, exp_c);
    check("l_rdata_end", bus.l_rdata, exp_l);
    check("busy_end", 32'(bus.busy), 32'd0);
  endtask

  // Abort a CPU read in WAIT with reset; no ack may ever appear for it
  task automatic reset_mid_wait();
    int acks;
    acks = 0;
    @(negedge clk);
    bus.c_req = 1'b1; bus.c_we = 1'b0; bus.c_addr = 8'h03;
    @(negedge clk);
    @(negedge clk);
    check("busy_pre_reset", 32'(bus.busy), 32'd1);
    reset = 1'b0;
    bus.c_req = 1'b0;
    model_last = 1'b1;
    exp_c = '0;
    exp_l = '0;
    @(negedge clk);
    check("busy_after_reset", 32'(bus.busy), 32'd0);
    if (bus.c_ack || bus.l_ack) acks++;
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (bus.c_ack || bus.l_ack) acks++;
    end
    check("no_ack_after_abort", acks, 0);
    check("c_rdata_after_reset", bus.c_rdata, 32'd0);
    check("mem_addr_after_reset", 32'(bus.mem_addr), 32'd0);
  endtask

  task automatic lat3_read(input logic [AW-1:0] a, input logic [DW-1:0] v);
    int acks;
    acks = 0;
    @(negedge clk);
    bus3.c_we = 1'b0; bus3.c_addr = a; bus3.c_req = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (bus3.c_ack) begin
        acks++;
        check("lat3_ack_time", k, LAT3 + 2);
        check("lat3_rdata", bus3.c_rdata, v);
        bus3.c_req = 1'b0;
      end
    end
    check("lat3_ack_count", acks, 1);
  endtask

  initial begin
    logic [DW-1:0] v;
    logic [DW-1:0] v5;
    logic [DW-1:0] v9;
    reset = 1'b0;
    bus.c_req = 1'b0;  bus.c_we = 1'b0;  bus.c_addr = '0;  bus.c_wdata = '0;
    bus.l_req = 1'b0;  bus.l_we = 1'b0;  bus.l_addr = '0;  bus.l_wdata = '0;
    bus3.c_req = 1'b0; bus3.c_we = 1'b0; bus3.c_addr = '0; bus3.c_wdata = '0;
    bus3.l_req = 1'b0; bus3.l_we = 1'b0; bus3.l_addr = '0; bus3.l_wdata = '0;

    for (int i = 0; i <= 32; i++) begin
      v = (i == 16) ? 32'hDEADBEEF : $urandom;
      mem_load(1'b0, AW'(i), v);
      ref_mem[i] = v;
    end
    v5 = $urandom;
    v9 = $urandom;
    mem_load(1'b1, 8'h05, v5);
    mem_load(1'b1, 8'h09, v9);

    check("rst_c_ack",   32'(bus.c_ack),  32'd0);
    check("rst_l_ack",   32'(bus.l_ack),  32'd0);
    check("rst_mem_en",  32'(bus.mem_en), 32'd0);
    check("rst_mem_we",  32'(bus.mem_we), 32'd0);
    check("rst_busy",    32'(bus.busy),   32'd0);
    check("rst_owner",   32'(bus.owner),  32'd0);
    check("rst_c_rdata", bus.c_rdata,     32'd0);
    check("rst_l_rdata", bus.l_rdata,     32'd0);
    check("rst_addr",    32'(bus.mem_addr), 32'd0);
    check("rst_wdata",   bus.mem_wdata,   32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Directed: CPU read, loader write then CPU read-back, four ties, drop/scramble
    run_round(1, 0, 0, 0, 8'h10, 8'h00, 32'h0, 32'h0, 0, 0);
    run_round(0, 1, 0, 1, 8'h00, 8'h20, 32'h0, 32'h12345678, 0, 0);
    run_round(1, 0, 0, 0, 8'h20, 8'h00, 32'h0, 32'h0, 0, 0);
    for (int t = 0; t < 4; t++)
      run_round(1, 1, 0, 0, AW'(t), AW'(t + 4), 32'h0, 32'h0, 0, 0);
    run_round(1, 0, 0, 0, 8'h07, 8'h00, 32'h0, 32'h0, 1, 1);

    // Randomized rounds
    for (int t = 0; t < 40; t++) begin
      int sel;
      sel = $urandom_range(0, 2);
      run_round(sel != 1, sel != 0, 1'($urandom), 1'($urandom),
                AW'($urandom_range(0, 31)), AW'($urandom_range(0, 31)),
                $urandom, $urandom, ($urandom_range(0, 3) == 0), 1'($urandom));
    end

    reset_mid_wait();
    run_round(1, 0, 0, 0, 8'h10, 8'h00, 32'h0, 32'h0, 0, 0);
    run_round(1, 1, 1, 0, 8'h11, 8'h12, $urandom, 32'h0, 0, 0);

    lat3_read(8'h05, v5);
    lat3_read(8'h09, v9);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
